// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external RAM port between IF fetch and MEM data access; MEM has fixed priority.
// Latency: req sampled at edge t, RAM bus held ACCESS_CYCLES cycles, ready pulses in the cycle after edge t+ACCESS_CYCLES.
// Backpressure: stallreq_o is raised while any request waits; optional single-entry fetch buffer via MEM_ARB_FETCH_BUF_EN.

module mem_port_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_ready_o,
   input  logic              mem_req_i,
   input  logic              mem_rw_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_ready_o,
   output logic              stallreq_o,
   output logic              ram_enable_o,
   output logic              ram_readWrite_o,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic [DATA_W-1:0] ram_dataWrite_o,
   input  logic [DATA_W-1:0] ram_dataRead_i
);

   typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   state_t            state;
   logic [3:0]        cnt;
   logic              mem_go;
   logic              if_go;
   logic              fb_hit;
   logic [DATA_W-1:0] fb_data;

   // A port whose ready is high this cycle is masked at the next edge: this
   // alternates service under contention and stops a held req being served twice.
   assign mem_go     = mem_req_i & ~mem_ready_o;
   assign if_go      = if_req_i  & ~if_ready_o;
   assign stallreq_o = if_go | mem_go;

`ifdef MEM_ARB_FETCH_BUF_EN
   logic              fb_valid;
   logic [ADDR_W-1:0] fb_addr;

   assign fb_hit = fb_valid & (fb_addr == if_addr_i);

   // Fetch buffer: refilled on every IF completion, invalidated when a MEM write is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_valid <= 1'b0;
         fb_addr  <= '0;
         fb_data  <= '0;
      end else if (state == IDLE && mem_go && mem_rw_i) begin
         fb_valid <= 1'b0;
      end else if (state == IF_ACC && cnt == LAST_CNT) begin
         fb_valid <= 1'b1;
         fb_addr  <= ram_address_o;
         fb_data  <= ram_dataRead_i;
      end
   end
`else
   assign fb_hit  = 1'b0;
   assign fb_data = '0;
`endif

   // Grant, sequence and complete accesses; RAM-side outputs double as the latched request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         ram_enable_o    <= 1'b0;
         ram_readWrite_o <= 1'b0;
         ram_address_o   <= '0;
         ram_dataWrite_o <= '0;
         if_ready_o      <= 1'b0;
         mem_ready_o     <= 1'b0;
         if_data_o       <= '0;
         mem_data_o      <= '0;
      end else begin
         if_ready_o  <= 1'b0;
         mem_ready_o <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (mem_go) begin
                  state           <= MEM_ACC;
                  ram_enable_o    <= 1'b1;
                  ram_readWrite_o <= mem_rw_i;
                  ram_address_o   <= mem_addr_i;
                  ram_dataWrite_o <= mem_rw_i ? mem_wdata_i : '0;
               end else if (if_go && fb_hit) begin
                  // Buffered fetch: answer next cycle without touching the RAM bus.
                  if_ready_o <= 1'b1;
                  if_data_o  <= fb_data;
               end else if (if_go) begin
                  state           <= IF_ACC;
                  ram_enable_o    <= 1'b1;
                  ram_readWrite_o <= 1'b0;
                  ram_address_o   <= if_addr_i;
                  ram_dataWrite_o <= '0;
               end
            end
            IF_ACC, MEM_ACC: begin
               if (cnt == LAST_CNT) begin
                  // Final edge: capture read data, pulse ready, and free the bus so the
                  // ready cycle is always a bus-idle turnaround cycle.
                  state           <= IDLE;
                  cnt             <= '0;
                  ram_enable_o    <= 1'b0;
                  ram_readWrite_o <= 1'b0;
                  ram_address_o   <= '0;
                  ram_dataWrite_o <= '0;
                  if (state == IF_ACC) begin
                     if_data_o  <= ram_dataRead_i;
                     if_ready_o <= 1'b1;
                  end else begin
                     mem_ready_o <= 1'b1;
                     if (!ram_readWrite_o) begin
                        mem_data_o <= ram_dataRead_i;
                     end
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               state        <= IDLE;
               cnt          <= '0;
               ram_enable_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: checks mem_port_arbiter with a cycle table plus hand-written multi-cycle sequences.
// Ready pulses are checked against a scoreboard of expected data and completion cycle.
// A small RAM model answers reads one half-cycle after the address is driven.

module tb_mem_port_arbiter;

   localparam int AC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [15:0] if_addr_i;
   logic [15:0] if_data_o;
   logic        if_ready_o;
   logic        mem_req_i;
   logic        mem_rw_i;
   logic [15:0] mem_addr_i;
   logic [15:0] mem_wdata_i;
   logic [15:0] mem_data_o;
   logic        mem_ready_o;
   logic        stallreq_o;
   logic        ram_enable_o;
   logic        ram_readWrite_o;
   logic [15:0] ram_address_o;
   logic [15:0] ram_dataWrite_o;
   logic [15:0] ram_dataRead_i;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(16), .DATA_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .if_req_i        (if_req_i),
      .if_addr_i       (if_addr_i),
      .if_data_o       (if_data_o),
      .if_ready_o      (if_ready_o),
      .mem_req_i       (mem_req_i),
      .mem_rw_i        (mem_rw_i),
      .mem_addr_i      (mem_addr_i),
      .mem_wdata_i     (mem_wdata_i),
      .mem_data_o      (mem_data_o),
      .mem_ready_o     (mem_ready_o),
      .stallreq_o      (stallreq_o),
      .ram_enable_o    (ram_enable_o),
      .ram_readWrite_o (ram_readWrite_o),
      .ram_address_o   (ram_address_o),
      .ram_dataWrite_o (ram_dataWrite_o),
      .ram_dataRead_i  (ram_dataRead_i)
   );

   // RAM model: preloaded during reset, written on enabled write cycles
   logic [15:0] ram_mem [logic [15:0]];
   always @(posedge clk) begin
      if (rst) begin
         ram_mem[16'h0040] = 16'h1234;
         ram_mem[16'h0100] = 16'hC0DE;
         ram_mem[16'h9000] = 16'h5A5A;
      end else if (ram_enable_o && ram_readWrite_o) begin
         ram_mem[ram_address_o] = ram_dataWrite_o;
      end
   end

   // Read data follows the address half a cycle later
   always @(negedge clk) begin
      ram_dataRead_i = ram_mem.exists(ram_address_o) ? ram_mem[ram_address_o] : 16'h0000;
   end

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } sb_t;

   typedef struct {
      logic        if_req;
      logic [15:0] if_addr;
      logic        mem_req;
      logic        mem_rw;
      logic [15:0] mem_addr;
      logic [15:0] mem_wdata;
      logic        push_if;
      logic        push_mem;
      logic [15:0] sb_data;
      logic        exp_en;
      logic        exp_rw;
      logic [15:0] exp_addr;
      logic [15:0] exp_wd;
      logic        exp_if_rdy;
      logic        exp_mem_rdy;
      logic        exp_stall;
   } vec_t;

   sb_t  if_q[$];
   sb_t  mem_q[$];
   vec_t vt[15];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   function automatic vec_t mk(logic ir, logic [15:0] ia, logic mr, logic mw, logic [15:0] ma,
                               logic [15:0] md, logic pi, logic pm, logic [15:0] sd,
                               logic en, logic rw, logic [15:0] ea, logic [15:0] ew,
                               logic eir, logic emr, logic es);
      vec_t v;
      v.if_req = ir;   v.if_addr = ia;   v.mem_req = mr;   v.mem_rw = mw;
      v.mem_addr = ma; v.mem_wdata = md; v.push_if = pi;   v.push_mem = pm;
      v.sb_data = sd;  v.exp_en = en;    v.exp_rw = rw;    v.exp_addr = ea;
      v.exp_wd = ew;   v.exp_if_rdy = eir; v.exp_mem_rdy = emr; v.exp_stall = es;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit is_mem, input logic [15:0] data, input int at_cyc);
      sb_t e;
      e.data = data;
      e.cyc  = at_cyc;
      if (is_mem) mem_q.push_back(e);
      else        if_q.push_back(e);
   endtask

   task automatic sb_pop(input bit is_mem);
      sb_t e;
      if ((is_mem && mem_q.size() == 0) || (!is_mem && if_q.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL %s unexpected ready pulse: got 1, expected 0 (cycle %0d)",
                  is_mem ? "mem" : "if", cyc);
      end else if (is_mem) begin
         e = mem_q.pop_front();
         chk("mem_data", {16'h0, mem_data_o}, {16'h0, e.data});
         chk("mem_ready_cycle", cyc, e.cyc);
      end else begin
         e = if_q.pop_front();
         chk("if_data", {16'h0, if_data_o}, {16'h0, e.data});
         chk("if_ready_cycle", cyc, e.cyc);
      end
   endtask

   // One clock: sample just after the edge and retire any ready pulse
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
         if (mem_ready_o) sb_pop(1'b1);
         if (if_ready_o)  sb_pop(1'b0);
      end
   endtask

   task automatic drive(input logic ir, input logic [15:0] ia, input logic mr, input logic mw,
                        input logic [15:0] ma, input logic [15:0] md);
      if_req_i    = ir;
      if_addr_i   = ia;
      mem_req_i   = mr;
      mem_rw_i    = mw;
      mem_addr_i  = ma;
      mem_wdata_i = md;
   endtask

   // Run until the scoreboard drains, dropping each req on its ready pulse
   task automatic wait_done(input string name, output int en_cycles);
      en_cycles = 0;
      for (int n = 0; n < 40 && (if_q.size() != 0 || mem_q.size() != 0); n++) begin
         tick();
         if (ram_enable_o) en_cycles++;
         if (mem_ready_o) mem_req_i = 1'b0;
         if (if_ready_o)  if_req_i  = 1'b0;
      end
      chk({name, "_pending"}, if_q.size() + mem_q.size(), 0);
   endtask

   initial begin
      int en_n;

      vt[0]  = mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
      vt[1]  = mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 0, 1);
      vt[2]  = mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 0, 1);
      vt[3]  = mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
      vt[4]  = mk(0, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      vt[5]  = mk(0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
      vt[6]  = mk(0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 0, 0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 0, 0, 1);
      vt[7]  = mk(0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 0, 0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 0, 0, 1);
      vt[8]  = mk(0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
      vt[9]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
      vt[10] = mk(0, 16'h0000, 1, 0, 16'h8000, 16'h7777, 0, 1, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
      vt[11] = mk(0, 16'h0000, 1, 0, 16'h8000, 16'h7777, 0, 0, 16'h0000, 1, 0, 16'h8000, 16'h0000, 0, 0, 1);
      vt[12] = mk(0, 16'h0000, 1, 0, 16'h8000, 16'h7777, 0, 0, 16'h0000, 1, 0, 16'h8000, 16'h0000, 0, 0, 1);
      vt[13] = mk(0, 16'h0000, 1, 0, 16'h8000, 16'h7777, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
      vt[14] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

      // Reset state
      rst = 1'b1;
      drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
      repeat (3) tick();
      chk("rst_enable", ram_enable_o, 0);
      chk("rst_rw", ram_readWrite_o, 0);
      chk("rst_addr", ram_address_o, 0);
      chk("rst_wdata", ram_dataWrite_o, 0);
      chk("rst_if_ready", if_ready_o, 0);
      chk("rst_mem_ready", mem_ready_o, 0);
      chk("rst_if_data", if_data_o, 0);
      chk("rst_mem_data", mem_data_o, 0);
      chk("rst_stall", stallreq_o, 0);
      rst = 1'b0;

      // Single IF read, MEM write, MEM read-back, cycle by cycle
      for (int i = 0; i < 15; i++) begin
         drive(vt[i].if_req, vt[i].if_addr, vt[i].mem_req, vt[i].mem_rw, vt[i].mem_addr, vt[i].mem_wdata);
         if (vt[i].push_if)  push(1'b0, vt[i].sb_data, cyc + 1 + AC);
         if (vt[i].push_mem) push(1'b1, vt[i].sb_data, cyc + 1 + AC);
         #1;
         chk($sformatf("row%0d_enable", i), ram_enable_o, vt[i].exp_en);
         chk($sformatf("row%0d_rw", i), ram_readWrite_o, vt[i].exp_rw);
         chk($sformatf("row%0d_addr", i), ram_address_o, vt[i].exp_addr);
         chk($sformatf("row%0d_wdata", i), ram_dataWrite_o, vt[i].exp_wd);
         chk($sformatf("row%0d_if_ready", i), if_ready_o, vt[i].exp_if_rdy);
         chk($sformatf("row%0d_mem_ready", i), mem_ready_o, vt[i].exp_mem_rdy);
         chk($sformatf("row%0d_stall", i), stallreq_o, vt[i].exp_stall);
         tick();
      end

      // Simultaneous requests: MEM first, IF after access plus turnaround
      drive(1, 16'h0100, 1, 0, 16'h9000, 16'h0000);
      push(1'b1, 16'h5A5A, cyc + 1 + AC);
      push(1'b0, 16'hC0DE, cyc + 2 + 2 * AC);
      wait_done("simultaneous", en_n);
      chk("simultaneous_bus_cycles", en_n, 2 * AC);
      repeat (4) tick();

      // Both requests held: MEM, IF, MEM, IF
      drive(1, 16'h0100, 1, 0, 16'h9000, 16'h0000);
      push(1'b1, 16'h5A5A, cyc + 1 + AC);
      push(1'b0, 16'hC0DE, cyc + 2 + 2 * AC);
      push(1'b1, 16'h5A5A, cyc + 3 + 3 * AC);
      push(1'b0, 16'hC0DE, cyc + 4 + 4 * AC);
      repeat (4 + 3 * AC) tick();
      drive(0, 16'h0100, 0, 0, 16'h9000, 16'h0000);
      wait_done("alternate", en_n);
      repeat (4) tick();

      // Reset in the second cycle of a MEM access, req held throughout
      drive(0, 16'h0000, 1, 0, 16'h9000, 16'h0000);
      tick();
      tick();
      chk("pre_reset_enable", ram_enable_o, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_enable", ram_enable_o, 0);
      chk("async_rst_addr", ram_address_o, 0);
      chk("async_rst_mem_ready", mem_ready_o, 0);
      tick();
      chk("in_rst_mem_ready", mem_ready_o, 0);
      tick();
      rst = 1'b0;
      push(1'b1, 16'h5A5A, cyc + 1 + AC);
      wait_done("restart", en_n);
      chk("restart_bus_cycles", en_n, AC);
      tick();

`ifdef MEM_ARB_FETCH_BUF_EN
      // Fetch buffer: miss, hit, invalidate by write, refetch
      drive(1, 16'h0040, 0, 0, 16'h0000, 16'h0000);
      push(1'b0, 16'h1234, cyc + 1 + AC);
      wait_done("fb_miss", en_n);
      chk("fb_miss_bus_cycles", en_n, AC);
      tick();
      drive(1, 16'h0040, 0, 0, 16'h0000, 16'h0000);
      push(1'b0, 16'h1234, cyc + 1);
      wait_done("fb_hit", en_n);
      chk("fb_hit_bus_cycles", en_n, 0);
      tick();
      drive(0, 16'h0000, 1, 1, 16'h0040, 16'hABCD);
      push(1'b1, 16'h5A5A, cyc + 1 + AC);
      wait_done("fb_write", en_n);
      tick();
      drive(1, 16'h0040, 0, 0, 16'h0000, 16'h0000);
      push(1'b0, 16'hABCD, cyc + 1 + AC);
      wait_done("fb_refetch", en_n);
      chk("fb_refetch_bus_cycles", en_n, AC);
      tick();
`endif

      repeat (3) tick();
      chk("final_if_queue", if_q.size(), 0);
      chk("final_mem_queue", mem_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
